// File: rtl/video_write_scheduler.sv
// CPU-to-video write queue: buffers iomem writes and releases them only during vertical blanking.
// Optional vblank interrupt enabled by defining VIDEO_WSCHED_IRQ_EN.
module video_write_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        vblank,
  output logic        vid_valid,
  output logic [3:0]  vid_wstrb,
  output logic [31:0] vid_addr,
  output logic [31:0] vid_wdata,
  output logic        irq
);

  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DRAIN} state_t;

  state_t               r_state, w_state_next;
  logic [67:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr, r_rptr;
  logic [LEVEL_W-1:0]   r_count, w_count_next;
  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic                 r_vid_valid;
  logic [3:0]           r_vid_wstrb;
  logic [31:0]          r_vid_addr, r_vid_wdata;
  logic                 r_vblank_d;
  logic [15:0]          r_frame_cnt;

  logic w_req, w_is_ctl, w_is_wr, w_qwr, w_full, w_pop, w_ack, w_push, w_flush;
  logic w_vb_rise, w_irq_pend;
  logic [7:0]  w_level8;
  logic [67:0] w_head;

  assign w_req     = iomem_valid && !r_ready;
  assign w_is_ctl  = (iomem_addr[23:20] == 4'hF);
  assign w_is_wr   = |iomem_wstrb;
  assign w_qwr     = !w_is_ctl && w_is_wr;
  assign w_full    = (r_count == LEVEL_W'(FIFO_DEPTH));
  // Control writes are always acknowledged, so flush need not wait on the ack term.
  assign w_flush   = w_req && w_is_ctl && iomem_wstrb[0] && iomem_wdata[1];
  assign w_pop     = (r_state == S_DRAIN) && (r_count != '0) && !w_flush;
  // A pop in the same cycle frees the slot, so a full queue still accepts while draining.
  assign w_ack     = w_req && (!w_qwr || !w_full || w_pop);
  assign w_push    = w_ack && w_qwr && !w_flush;
  assign w_vb_rise = vblank && !r_vblank_d;
  assign w_level8  = 8'(r_count);
  assign w_head    = r_mem[r_rptr];

  always_comb begin
    w_count_next = r_count;
    if (w_flush) begin
      w_count_next = '0;
    end else begin
      if (w_push) w_count_next = w_count_next + LEVEL_W'(1);
      if (w_pop)  w_count_next = w_count_next - LEVEL_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_next = vblank ? S_DRAIN : S_HOLD;
      end
      S_HOLD: begin
        if (r_count == '0)  w_state_next = S_IDLE;
        else if (vblank)    w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_count_next == '0) w_state_next = S_IDLE;
        else if (!vblank)       w_state_next = S_HOLD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {iomem_wstrb, iomem_addr, iomem_wdata};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_vid_valid <= 1'b0;
      r_vid_wstrb <= '0;
      r_vid_addr  <= '0;
      r_vid_wdata <= '0;
      r_vblank_d  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_ready    <= w_ack;
      r_count    <= w_count_next;
      r_vblank_d <= vblank;
      if (w_vb_rise) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      end

      r_rdata <= '0;
      if (w_ack && w_is_ctl && !w_is_wr)
        r_rdata <= {r_frame_cnt, w_level8, 5'b0, w_irq_pend, w_full, vblank};

      r_vid_valid <= w_pop;
      if (w_pop) {r_vid_wstrb, r_vid_addr, r_vid_wdata} <= w_head;
    end
  end

`ifdef VIDEO_WSCHED_IRQ_EN
  logic r_irq_pend, r_irq, w_irq_clr;

  assign w_irq_clr = w_ack && w_is_ctl && iomem_wstrb[0] && iomem_wdata[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq_pend <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_vb_rise)      r_irq_pend <= 1'b1;
      else if (w_irq_clr) r_irq_pend <= 1'b0;
      r_irq <= r_irq_pend;
    end
  end

  assign w_irq_pend = r_irq_pend;
  assign irq        = r_irq;
`else
  assign w_irq_pend = 1'b0;
  assign irq        = 1'b0;
`endif

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign vid_valid   = r_vid_valid;
  assign vid_wstrb   = r_vid_wstrb;
  assign vid_addr    = r_vid_addr;
  assign vid_wdata   = r_vid_wdata;

endmodule
